// File: rtl/piso_ctrl.sv
// rtl/piso_ctrl.sv - Load/shift sequencer that frames parallel words for a piso shift register
//
// Purpose: accepts a word on a valid/ready handshake, loads it into a downstream
// piso, then enables that piso for DATA_WIDTH shift cycles. frame_o marks those
// cycles. After the last bit it pulses done_o and, optionally, holds an idle gap
// before accepting the next word.
//
// Ports:
//   clk_i            - clock, all logic on posedge
//   s_rst_n_i        - synchronous active-low reset
//   s_valid_i        - upstream word valid
//   s_data_i         - upstream word
//   s_ready_o        - high in IDLE only
//   abort_i          - cancel the current word and return to IDLE
//   piso_wr_enable_o - piso load strobe (LOAD state)
//   piso_enable_o    - piso shift enable (SHIFT state)
//   piso_data_o      - captured word, held until the next accepted word
//   frame_o          - high while the word's bits are on the serial line
//   busy_o           - high in any state other than IDLE
//   done_o           - one-cycle pulse after the last bit of a non-aborted word
module piso_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  clk_i,
    input  logic                  s_rst_n_i,
    input  logic                  s_valid_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  s_ready_o,
    input  logic                  abort_i,
    output logic                  piso_wr_enable_o,
    output logic                  piso_enable_o,
    output logic [DATA_WIDTH-1:0] piso_data_o,
    output logic                  frame_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int CNT_WIDTH  = $clog2(DATA_WIDTH);
    localparam int GAP_WIDTH  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int GAP_LOAD_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam bit HAS_GAP    = (GAP_CYCLES > 0);

    localparam logic [CNT_WIDTH-1:0] BIT_LOAD = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [GAP_WIDTH-1:0] GAP_LOAD = GAP_WIDTH'(GAP_LOAD_I);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GAP_WIDTH-1:0]    gap_cnt_q, gap_cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    done_q, done_d;

    always_ff @(posedge clk_i) begin
        if (!s_rst_n_i) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            data_q    <= data_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        data_d    = data_q;
        done_d    = 1'b0;

        // Abort wins over everything except reset, including an IDLE handshake.
        if (abort_i) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // s_ready_o is high throughout IDLE, so valid alone completes the handshake.
                    if (s_valid_i) begin
                        data_d  = s_data_i;
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = BIT_LOAD;
                end
                ST_SHIFT: begin
                    if (bit_cnt_q == '0) begin
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                        if (HAS_GAP) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = GAP_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // All strobes come from the state register so no input reaches an output combinationally.
    assign s_ready_o        = (state_q == ST_IDLE);
    assign busy_o           = (state_q != ST_IDLE);
    assign piso_wr_enable_o = (state_q == ST_LOAD);
    assign piso_enable_o    = (state_q == ST_SHIFT);
    assign frame_o          = (state_q == ST_SHIFT);
    assign piso_data_o      = data_q;
    assign done_o           = done_q;

endmodule

// File: tb/tb_piso_ctrl.sv
// tb/tb_piso_ctrl.sv - Self-checking bench for piso_ctrl with GAP_CYCLES of 0 and 3
module tb_piso_ctrl;

    localparam int DW = 8;
    localparam int G0 = 0;
    localparam int G1 = 3;

    logic          clk;
    logic          rst_n;
    logic          valid;
    logic [DW-1:0] data;
    logic          abort;

    logic          ready [2];
    logic          wr    [2];
    logic          en    [2];
    logic [DW-1:0] pdata [2];
    logic          frame [2];
    logic          busy  [2];
    logic          done  [2];

    int checks   = 0;
    int failures = 0;

    // Reference model: phase = cycles since acceptance (-1 when idle).
    int            phase  [2];
    logic [DW-1:0] word   [2];
    logic          exp_dn [2];
    int            gap_of [2];

    // Stand-in piso: loads on wr_enable, shifts MSB-first on enable.
    logic [DW-1:0] sreg [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    piso_ctrl #(.DATA_WIDTH(DW), .GAP_CYCLES(G0)) u_dut0 (
        .clk_i(clk), .s_rst_n_i(rst_n), .s_valid_i(valid), .s_data_i(data),
        .s_ready_o(ready[0]), .abort_i(abort), .piso_wr_enable_o(wr[0]),
        .piso_enable_o(en[0]), .piso_data_o(pdata[0]), .frame_o(frame[0]),
        .busy_o(busy[0]), .done_o(done[0])
    );

    piso_ctrl #(.DATA_WIDTH(DW), .GAP_CYCLES(G1)) u_dut1 (
        .clk_i(clk), .s_rst_n_i(rst_n), .s_valid_i(valid), .s_data_i(data),
        .s_ready_o(ready[1]), .abort_i(abort), .piso_wr_enable_o(wr[1]),
        .piso_enable_o(en[1]), .piso_data_o(pdata[1]), .frame_o(frame[1]),
        .busy_o(busy[1]), .done_o(done[1])
    );

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (wr[g]) sreg[g] <= pdata[g];
            else if (en[g]) sreg[g] <= sreg[g] << 1;
        end
    end

    task automatic chk(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d t=%0t observed=%0h expected=%0h", tag, g, $time, obs, exp);
        end
    endtask

    task automatic model_edge(input int g);
        if (!rst_n) begin
            phase[g]  = -1;
            exp_dn[g] = 1'b0;
            word[g]   = '0;
        end else begin
            exp_dn[g] = (phase[g] == DW + 1) && !abort;
            if (abort && phase[g] >= 0) begin
                phase[g] = -1;
            end else if (phase[g] < 0) begin
                if (valid && !abort) begin
                    phase[g] = 1;
                    word[g]  = data;
                end
            end else begin
                phase[g]++;
                if (phase[g] == DW + 2 + gap_of[g]) phase[g] = -1;
            end
        end
    endtask

    task automatic check_outputs(input int g);
        logic exp_frame;
        exp_frame = (phase[g] >= 2) && (phase[g] <= DW + 1);
        chk("ready", g, 32'(ready[g]), 32'(phase[g] < 0));
        chk("busy",  g, 32'(busy[g]),  32'(phase[g] >= 0));
        chk("wr_en", g, 32'(wr[g]),    32'(phase[g] == 1));
        chk("en",    g, 32'(en[g]),    32'(exp_frame));
        chk("frame", g, 32'(frame[g]), 32'(exp_frame));
        chk("done",  g, 32'(done[g]),  32'(exp_dn[g]));
        chk("pdata", g, 32'(pdata[g]), 32'(word[g]));
        if (exp_frame) begin
            chk("serial", g, 32'(sreg[g][DW-1]), 32'(word[g][DW-1-(phase[g]-2)]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        check_outputs(0);
        check_outputs(1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        gap_of[0] = G0;
        gap_of[1] = G1;
        for (int g = 0; g < 2; g++) begin
            phase[g]  = -1;
            word[g]   = '0;
            exp_dn[g] = 1'b0;
            sreg[g]   = '0;
        end

        // Reset held with a valid word pending: nothing captured.
        rst_n = 1'b0; valid = 1'b1; data = 8'h55; abort = 1'b0;
        ticks(3);
        rst_n = 1'b1; valid = 1'b0;
        ticks(2);

        // Single word 0xA5.
        valid = 1'b1; data = 8'hA5;
        tick();
        valid = 1'b0;
        ticks(16);

        // Back-to-back words with valid held.
        valid = 1'b1; data = 8'h3C;
        tick();
        data = 8'hC3;
        ticks(12);
        valid = 1'b0;
        ticks(16);

        // Abort in the 4th SHIFT cycle of 0xFF, then 0x81.
        valid = 1'b1; data = 8'hFF;
        tick();
        valid = 1'b0; data = 8'h81;
        ticks(4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        ticks(16);

        // Reset in the middle of SHIFT.
        valid = 1'b1; data = 8'h5A;
        tick();
        valid = 1'b0;
        ticks(3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ticks(3);

        // Abort and valid together in IDLE: no acceptance.
        abort = 1'b1; valid = 1'b1; data = 8'h77;
        tick();
        abort = 1'b0; valid = 1'b0;
        ticks(2);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            valid = ($urandom_range(0, 2) != 0);
            data  = DW'($urandom);
            abort = ($urandom_range(0, 19) == 0);
            rst_n = ($urandom_range(0, 79) != 0);
            tick();
        end
        valid = 1'b0; abort = 1'b0; rst_n = 1'b1;
        ticks(16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
